// File: rtl/act_loader_pkg.sv
// Shared types and widths for the activation loader.
// Optional build macro: ACT_LOADER_TRANSPOSE_EN selects column-major
// write addressing; the default build fills activation memory row-major.
package act_loader_pkg;

  localparam int ACT_W  = 7;
  localparam int ADDR_W = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT_W = 3'd2,
    ST_CAL    = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

  // Beat index to activation-memory address.
  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] idx);
`ifdef ACT_LOADER_TRANSPOSE_EN
    return {idx[2:0], idx[5:3]};
`else
    return idx;
`endif
  endfunction

endpackage

// File: rtl/activation_loader.sv
// Activation loader: streams DEPTH activation beats into activation memory,
// waits for weight loading to finish, then runs a fixed-length compute phase.
// Optional build macro: ACT_LOADER_TRANSPOSE_EN (column-major address fill).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | memory write window closed, waiting for start
// LOAD    | accepting beats; one extra cycle after the last beat so it is written
// WAIT_W  | all beats written, waiting for weight_done
// CAL     | compute phase, Cal high for CAL_CYCLES cycles
// FIN     | one-cycle done pulse, back to IDLE
module activation_loader
  import act_loader_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int CAL_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACT_W-1:0]  act_in,
  input  logic              act_in_valid,
  output logic              act_in_ready,
  input  logic              weight_done,
  output logic [ACT_W-1:0]  Activation,
  output logic [ADDR_W-1:0] Activation_Mem_Address_in,
  output logic              load_mem_done,
  output logic              Cal,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int CAL_W = $clog2(CAL_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CAL_W-1:0]   cal_q, cal_d;
  logic               flag_q, flag_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               weights_ready;

  // Sticky weight_done, including a pulse arriving this very cycle.
  assign weights_ready = flag_q | weight_done;

  // State and datapath registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cal_q   <= '0;
      flag_q  <= 1'b0;
      act_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cal_q   <= cal_d;
      flag_q  <= flag_d;
      act_q   <= act_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state, beat capture and Moore outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    cal_d         = cal_q;
    flag_d        = flag_q;
    act_d         = act_q;
    addr_d        = addr_q;
    act_in_ready  = 1'b0;
    load_mem_done = 1'b1;
    Cal           = 1'b0;
    done          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        flag_d = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          act_d   = '0;
          addr_d  = '0;
        end
      end
      ST_LOAD: begin
        load_mem_done = 1'b0;
        flag_d        = weights_ready;
        if (cnt_q != CNT_W'(DEPTH)) begin
          act_in_ready = 1'b1;
          if (act_in_valid) begin
            act_d  = act_in;
            addr_d = map_addr(ADDR_W'(cnt_q));
            cnt_d  = cnt_q + CNT_W'(1);
          end
        end else if (weights_ready) begin
          // Last beat has had its write cycle; weights already in.
          state_d = ST_CAL;
          cal_d   = CAL_W'(CAL_CYCLES - 1);
        end else begin
          state_d = ST_WAIT_W;
        end
      end
      ST_WAIT_W: begin
        load_mem_done = 1'b0;
        flag_d        = weights_ready;
        if (weights_ready) begin
          state_d = ST_CAL;
          cal_d   = CAL_W'(CAL_CYCLES - 1);
        end
      end
      ST_CAL: begin
        Cal = 1'b1;
        if (cal_q == '0) state_d = ST_FIN;
        else             cal_d   = cal_q - CAL_W'(1);
      end
      ST_FIN: begin
        done    = 1'b1;
        flag_d  = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy                      = (state_q != ST_IDLE);
  assign Activation                = act_q;
  assign Activation_Mem_Address_in = addr_q;

endmodule

// File: tb/tb_activation_loader.sv
// Directed self-checking bench for activation_loader.
module tb_activation_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] act_in;
  logic       act_in_valid;
  logic       act_in_ready;
  logic       weight_done;
  logic [6:0] Activation;
  logic [5:0] Activation_Mem_Address_in;
  logic       load_mem_done;
  logic       Cal;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  activation_loader #(.DEPTH(64), .CAL_CYCLES(8)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .start                     (start),
    .act_in                    (act_in),
    .act_in_valid              (act_in_valid),
    .act_in_ready              (act_in_ready),
    .weight_done               (weight_done),
    .Activation                (Activation),
    .Activation_Mem_Address_in (Activation_Mem_Address_in),
    .load_mem_done             (load_mem_done),
    .Cal                       (Cal),
    .busy                      (busy),
    .done                      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] exp_addr(input int i);
    logic [5:0] b;
    b = 6'(i);
`ifdef ACT_LOADER_TRANSPOSE_EN
    return {b[2:0], b[5:3]};
`else
    return b;
`endif
  endfunction

  initial begin
    int         cal_n;
    int         done_n;
    logic [5:0] ea;
    logic [6:0] ed;

    rst = 1'b1; start = 1'b0; act_in = '0; act_in_valid = 1'b0; weight_done = 1'b0;
    tick(); tick();
    chk("rst_ld",    32'(load_mem_done), 32'd1);
    chk("rst_cal",   32'(Cal),           32'd0);
    chk("rst_rdy",   32'(act_in_ready),  32'd0);
    chk("rst_busy",  32'(busy),          32'd0);
    chk("rst_done",  32'(done),          32'd0);
    chk("rst_addr",  32'(Activation_Mem_Address_in), 32'd0);
    chk("rst_act",   32'(Activation),    32'd0);
    rst = 1'b0;
    tick();

    // Pass A: back-to-back beats, weight_done at beat 20
    start = 1'b1; tick(); start = 1'b0;
    chk("a_entry_rdy",  32'(act_in_ready), 32'd1);
    chk("a_entry_ld",   32'(load_mem_done), 32'd0);
    chk("a_entry_busy", 32'(busy), 32'd1);
    chk("a_entry_addr", 32'(Activation_Mem_Address_in), 32'd0);
    chk("a_entry_act",  32'(Activation), 32'd0);
    for (int i = 0; i < 64; i++) begin
      act_in = 7'(i); act_in_valid = 1'b1; weight_done = (i == 20);
      tick();
      chk("a_beat_addr", 32'(Activation_Mem_Address_in), 32'(exp_addr(i)));
      chk("a_beat_act",  32'(Activation), 32'(i));
      chk("a_beat_ld",   32'(load_mem_done), 32'd0);
    end
    act_in_valid = 1'b0; weight_done = 1'b0;
    chk("a_tail_ld",  32'(load_mem_done), 32'd0);
    chk("a_tail_rdy", 32'(act_in_ready), 32'd0);
    chk("a_tail_cal", 32'(Cal), 32'd0);
    tick();
    chk("a_cal_entry", 32'(Cal), 32'd1);
    chk("a_cal_ld",    32'(load_mem_done), 32'd1);
    chk("a_cal_addr",  32'(Activation_Mem_Address_in), 32'(exp_addr(63)));
    chk("a_cal_act",   32'(Activation), 32'd63);
    cal_n = 1; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (Cal) cal_n++;
      if (done) done_n++;
    end
    chk("a_cal_len", 32'(cal_n), 32'd8);
    chk("a_done_n",  32'(done_n), 32'd1);
    chk("a_idle",    32'(busy), 32'd0);

    // Pass B: stray weight_done in IDLE, 50% valid, late weight_done
    weight_done = 1'b1; tick(); weight_done = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    ea = '0; ed = '0;
    for (int i = 0; i < 64; i++) begin
      act_in_valid = 1'b0; act_in = 7'h7f;
      tick();
      chk("b_gap_addr", 32'(Activation_Mem_Address_in), 32'(ea));
      chk("b_gap_act",  32'(Activation), 32'(ed));
      act_in_valid = 1'b1; act_in = 7'((i * 5 + 3) & 127);
      tick();
      ea = exp_addr(i); ed = 7'((i * 5 + 3) & 127);
      chk("b_beat_addr", 32'(Activation_Mem_Address_in), 32'(ea));
      chk("b_beat_act",  32'(Activation), 32'(ed));
    end
    act_in_valid = 1'b0;
    for (int t = 0; t < 5; t++) begin
      chk("b_wait_ld",   32'(load_mem_done), 32'd0);
      chk("b_wait_cal",  32'(Cal), 32'd0);
      chk("b_wait_busy", 32'(busy), 32'd1);
      chk("b_wait_addr", 32'(Activation_Mem_Address_in), 32'(ea));
      chk("b_wait_act",  32'(Activation), 32'(ed));
      tick();
    end
    chk("b_still_wait", 32'(Cal), 32'd0);
    weight_done = 1'b1; tick(); weight_done = 1'b0;
    chk("b_cal_entry", 32'(Cal), 32'd1);
    cal_n = 1; done_n = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (Cal) cal_n++;
      if (done) done_n++;
    end
    chk("b_cal_len", 32'(cal_n), 32'd8);
    chk("b_done_n",  32'(done_n), 32'd1);

    // Pass C: weight_done on the last beat, start during CAL
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      act_in = 7'(63 - i); act_in_valid = 1'b1; weight_done = (i == 63);
      tick();
      chk("c_beat_addr", 32'(Activation_Mem_Address_in), 32'(exp_addr(i)));
    end
    act_in_valid = 1'b0; weight_done = 1'b0;
    chk("c_tail_ld", 32'(load_mem_done), 32'd0);
    tick();
    chk("c_no_wait", 32'(Cal), 32'd1);
    cal_n = 1; done_n = 0;
    start = 1'b1; tick(); start = 1'b0;
    if (Cal) cal_n++;
    if (done) done_n++;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (Cal) cal_n++;
      if (done) done_n++;
    end
    chk("c_cal_len", 32'(cal_n), 32'd8);
    chk("c_done_n",  32'(done_n), 32'd1);
    chk("c_start_ignored", 32'(busy), 32'd0);

    // Pass D: asynchronous reset after 10 beats
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      act_in = 7'(i + 40); act_in_valid = 1'b1;
      tick();
    end
    chk("d_pre_addr", 32'(Activation_Mem_Address_in), 32'(exp_addr(9)));
    #2 rst = 1'b1;
    #1;
    chk("d_rst_ld",   32'(load_mem_done), 32'd1);
    chk("d_rst_addr", 32'(Activation_Mem_Address_in), 32'd0);
    chk("d_rst_act",  32'(Activation), 32'd0);
    chk("d_rst_busy", 32'(busy), 32'd0);
    chk("d_rst_rdy",  32'(act_in_ready), 32'd0);
    act_in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("d_post_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/activation_loader.md
ACTIVATION_LOADER -- requirements
Module: activation_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64: activation beats per load, power of two.
REQ-002 SHALL have parameter CAL_CYCLES, default 8: cycles Cal is held high.
REQ-003 SHALL have port clk  input  1  clock; rising-edge active.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load/compute pass.
REQ-006 SHALL have port act_in  input  7  incoming activation value.
REQ-007 SHALL have port act_in_valid  input  1  act_in is valid.
REQ-008 SHALL have port act_in_ready  output  1  loader accepts act_in this cycle.
REQ-009 SHALL have port weight_done  input  1  pulse: weight/compensation loading finished.
REQ-010 SHALL have port Activation  output  7  data to activation memory.
REQ-011 SHALL have port Activation_Mem_Address_in  output  6  write address to activation memory.
REQ-012 SHALL have port load_mem_done  output  1  0 = memory write window open, 1 = closed.
REQ-013 SHALL have port Cal  output  1  compute phase active.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of pass.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, WAIT_W, CAL, FIN.
REQ-017 SHALL, in IDLE, drive load_mem_done=1, Cal=0, act_in_ready=0; start moves to LOAD next edge.
REQ-018 SHALL, in LOAD/WAIT_W, drive load_mem_done=0 (memory writes every cycle while 0).
REQ-019 SHALL drive act_in_ready=1 in LOAD only; a beat is accepted when act_in_valid && act_in_ready.
REQ-020 SHALL register an accepted beat: Activation=act_in and Activation_Mem_Address_in=beat count, both valid from the edge of acceptance.
REQ-021 SHALL hold Activation and address unchanged between beats so repeated memory writes are idempotent.
REQ-022 SHALL on LOAD entry drive address 0, data 0; the resulting write to address 0 is overwritten by beat 0.
REQ-023 SHALL latch weight_done in a sticky flag from the LOAD entry edge until FIN; weight_done in IDLE ignored.
REQ-024 SHALL leave LOAD after beat DEPTH-1: to CAL if flag set (or weight_done that cycle), else WAIT_W.
REQ-025 SHALL remain in LOAD/WAIT_W one cycle after the last beat with load_mem_done=0 so the last beat is written.
REQ-026 SHALL leave WAIT_W for CAL the cycle after weight_done is seen.
REQ-027 SHALL in CAL drive load_mem_done=1, Cal=1 for exactly CAL_CYCLES cycles, then enter FIN.
REQ-028 SHALL in FIN drive Cal=0, load_mem_done=1, done=1 for one cycle, then return to IDLE.
REQ-029 SHALL ignore start when busy=1.
REQ-030 SHALL size the beat counter log2(DEPTH)+1 bits; no wrap within a pass.

Reset
REQ-031 SHALL on rst, at any state, immediately force IDLE, load_mem_done=1, Cal=0, act_in_ready=0, busy=0, done=0, Activation=0, address=0, flag=0, counters=0.

Configuration
REQ-032 SHALL, with ACT_LOADER_TRANSPOSE_EN defined, drive address = {count[2:0], count[5:3]} (column-major fill).
REQ-033 SHALL, without ACT_LOADER_TRANSPOSE_EN, drive address = count[5:0] (row-major fill).

Structure
REQ-034 SHALL place state enum, ACT_W=7, ADDR_W=6 in shared package act_loader_pkg.
REQ-035 SHALL be one module; no sub-module needed.

Verification
REQ-036 Reset mid-LOAD after 10 beats -> load_mem_done=1, address=0, state IDLE same cycle.
REQ-037 start, 64 back-to-back beats value=addr, weight_done at beat 20 -> addresses 0..63 in order, CAL entered 2 cycles after beat 63, Cal high 8 cycles, done pulse once.
REQ-038 act_in_valid toggling 50%, weight_done after last beat by 5 cycles -> WAIT_W held, outputs frozen at address 63, then CAL.
REQ-039 weight_done coincident with beat 63 -> no WAIT_W, CAL follows.
REQ-040 start during CAL -> ignored, single done pulse; ACT_LOADER_TRANSPOSE_EN build: beat 1 -> address 8, beat 9 -> address 9.
